reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Generates the design's board-level reset pulses: the producing end of the resetn lines that downstream blocks consume, including the LED reset indicator. It debounces a front-panel button, accepts a one-cycle software reset request, and monitors clock-generator lock. On any trigger, or after its own reset, it holds two reset outputs low for a fixed time, then releases them in order: peripheral first, core later. It also keeps a saturating count of generated resets for status readback.

## Interface
- DEBOUNCE_CYCLES, 3200000, consecutive stable cycles required to accept a button level change (10 ms at 320 MHz); ≥1
- HOLD_CYCLES, 256, cycles both outputs are held low once lock is present; ≥1
- STAGGER_CYCLES, 16, cycles periph_resetn is high before core_resetn rises; ≥1
- BUTTON_ACTIVE, 1, level of button_in when pressed

- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- button_in  in  1  asynchronous front-panel button
- sw_reset_req  in  1  single-cycle software reset request, synchronous to clk
- locked  in  1  asynchronous clock-generator lock status
- periph_resetn  out  1  peripheral reset, active-low, registered
- core_resetn  out  1  core reset, active-low, registered
- busy  out  1  high while any reset sequence is in progress
- reset_count  out  16  number of triggers accepted since resetn, saturating at 0xFFFF

## Operation
- **Synchronizers.** button_in and locked each pass through two flops before use.
  - Reset values: button synchronizer = !BUTTON_ACTIVE; lock synchronizer = 0.
- **Debounce.**
  - The debounced button level starts at !BUTTON_ACTIVE.
  - A counter increments each cycle the synchronized level differs from the debounced level. It clears whenever they agree.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A press event is a debounced transition to BUTTON_ACTIVE. Holding the button generates no further events; release generates none.
- **Lock loss.** A trigger occurs when the synchronized lock goes 1→0, detected against a registered copy.
- **Triggers.** A trigger is any of: press event, sw_reset_req=1, lock loss.
  - Simultaneous triggers in one cycle count as one trigger.
- **States.**
  - HOLD: both outputs 0, busy 1. The hold counter counts HOLD_CYCLES cycles but only advances while synchronized lock = 1. When it expires, go to STAGGER.
  - STAGGER: periph_resetn 1, core_resetn 0, busy 1. After STAGGER_CYCLES cycles, go to RUN.
  - RUN: both outputs 1, busy 0.
- **Retrigger.** A trigger in any state forces HOLD with the hold counter reloaded and the stagger counter cleared.
  - Lock low during STAGGER or RUN without a 1→0 edge is impossible, because the edge always occurs first.
  - In HOLD, lock low stalls the hold counter; the counter resumes without reloading when lock returns.
- **reset_count.** Increments by 1 per accepted trigger and stops at 0xFFFF.
  - The power-up sequence after resetn does not count.
- **Counter widths.** Counter widths are $clog2 of parameter+1; no wrap is permitted.

## Timing
- **While resetn = 0:** state = HOLD with counters loaded, periph_resetn = 0, core_resetn = 0, busy = 1, reset_count = 0, debounce state cleared.
- **After resetn rises:** with lock already high, periph_resetn rises exactly HOLD_CYCLES + 2 cycles after the first cycle with resetn = 1. The 2 cycles come from lock synchronizer fill.
- **Registered outputs.** Outputs are registered decodes of the state. A trigger sampled at edge k drives both outputs low from edge k+1.
- **Trigger latency.**
  - sw_reset_req: outputs low 1 cycle after the request.
  - Button: outputs low 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after a clean press edge.
  - Lock loss: outputs low 3 cycles after locked falls.
- **Pulse widths.**
  - HOLD with lock steady is exactly HOLD_CYCLES cycles.
  - periph_resetn leads core_resetn by exactly STAGGER_CYCLES cycles.
  - busy falls on the same edge that core_resetn rises.
- **Glitch rejection.** A button glitch shorter than DEBOUNCE_CYCLES cycles of synchronized level produces no event.
- **reset_count timing.** reset_count updates on the same edge that HOLD is entered.

## Test plan
Test parameters: DEBOUNCE_CYCLES=8, HOLD_CYCLES=4, STAGGER_CYCLES=3, BUTTON_ACTIVE=1.

- **Power-up:** resetn low 5 cycles, locked=1 → outputs 0 throughout reset; periph_resetn rises 6 cycles after resetn rises; core_resetn 3 cycles later; busy falls with core; reset_count=0.
- **Software request:** in RUN, pulse sw_reset_req 1 cycle → both outputs low next cycle for 4 cycles, staggered release (3 cycles); reset_count=1.
- **Button debounce:**
  - A 5-cycle pulse produces no trigger.
  - A press held 40 cycles produces exactly one sequence, starting 11 cycles after the rising edge.
  - Release produces none; reset_count=1.
- **Lock loss:** drop locked for 20 cycles during RUN → outputs low 3 cycles after the fall; HOLD stalls while lock is low; release occurs 4 cycles after synchronized lock returns; reset_count=1.
- **Retrigger and simultaneity:** sw_reset_req during STAGGER → core_resetn stays low, periph_resetn falls, HOLD restarts at full length. sw_reset_req in the same cycle as a press event → reset_count increments by 1.
- **Saturation:** force 65536 sw requests → reset_count holds at 0xFFFF, and sequencing still operates.

Source files
------------

// File: rtl/reset_sequencer.sv
// Board-level reset generator: debounced button, software request and
// clock-lock loss drive a held-then-staggered periph/core reset release.
module reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 3200000,
  parameter int HOLD_CYCLES     = 256,
  parameter int STAGGER_CYCLES  = 16,
  parameter bit BUTTON_ACTIVE   = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        button_in,
  input  logic        sw_reset_req,
  input  logic        locked,
  output logic        periph_resetn,
  output logic        core_resetn,
  output logic        busy,
  output logic [15:0] reset_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);

  localparam logic          BTN_IDLE  = ~BUTTON_ACTIVE;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_STAGGER,
    ST_RUN
  } state_e;

  logic          btn_s1_q, btn_s1_d;
  logic          btn_s2_q, btn_s2_d;
  logic          lock_s1_q, lock_s1_d;
  logic          lock_s2_q, lock_s2_d;
  logic          lock_prev_q, lock_prev_d;
  logic          db_q, db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          press_q, press_d;
  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] stag_q, stag_d;
  logic          periph_q, periph_d;
  logic          core_q, core_d;
  logic          busy_q, busy_d;
  logic [15:0]   count_q, count_d;
  logic          trig;

  always_comb begin
    btn_s1_d    = button_in;
    btn_s2_d    = btn_s1_q;
    lock_s1_d   = locked;
    lock_s2_d   = lock_s1_q;
    lock_prev_d = lock_s2_q;
    db_d        = db_q;
    db_cnt_d    = '0;
    press_d     = 1'b0;
    state_d     = state_q;
    hold_d      = hold_q;
    stag_d      = stag_q;
    count_d     = count_q;

    if (btn_s2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d    = btn_s2_q;
        press_d = (btn_s2_q == BUTTON_ACTIVE);
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    trig = press_q | sw_reset_req | (lock_prev_q & ~lock_s2_q);

    if (trig) begin
      state_d = ST_HOLD;
      hold_d  = HOLD_INIT;
      stag_d  = '0;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          // Hold time only accrues while the clock generator is locked
          if (lock_s2_q) begin
            if (hold_q == HOLD_LAST) state_d = ST_STAGGER;
            else hold_d = hold_q - 1'b1;
          end
        end
        ST_STAGGER: begin
          if (stag_q == STAG_LAST) state_d = ST_RUN;
          else stag_d = stag_q + 1'b1;
        end
        ST_RUN: ;
        default: begin
          state_d = ST_HOLD;
          hold_d  = HOLD_INIT;
          stag_d  = '0;
        end
      endcase
    end

    periph_d = (state_d != ST_HOLD);
    core_d   = (state_d == ST_RUN);
    busy_d   = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      btn_s1_q    <= BTN_IDLE;
      btn_s2_q    <= BTN_IDLE;
      lock_s1_q   <= 1'b0;
      lock_s2_q   <= 1'b0;
      lock_prev_q <= 1'b0;
      db_q        <= BTN_IDLE;
      db_cnt_q    <= '0;
      press_q     <= 1'b0;
      state_q     <= ST_HOLD;
      hold_q      <= HOLD_INIT;
      stag_q      <= '0;
      periph_q    <= 1'b0;
      core_q      <= 1'b0;
      busy_q      <= 1'b1;
      count_q     <= '0;
    end else begin
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      lock_s1_q   <= lock_s1_d;
      lock_s2_q   <= lock_s2_d;
      lock_prev_q <= lock_prev_d;
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      stag_q      <= stag_d;
      periph_q    <= periph_d;
      core_q      <= core_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
    end
  end

  assign periph_resetn = periph_q;
  assign core_resetn   = core_q;
  assign busy          = busy_q;
  assign reset_count   = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timestamp reference model feeding a
// per-cycle scoreboard, plus directed latency checks.
module tb_reset_sequencer;

  localparam int D  = 8;
  localparam int H  = 4;
  localparam int S  = 3;
  localparam bit BA = 1'b1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        button_in = ~BA;
  logic        sw_reset_req = 1'b0;
  logic        locked = 1'b1;
  logic        periph_resetn;
  logic        core_resetn;
  logic        busy;
  logic [15:0] reset_count;

  reset_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .STAGGER_CYCLES (S),
    .BUTTON_ACTIVE  (BA)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .button_in    (button_in),
    .sw_reset_req (sw_reset_req),
    .locked       (locked),
    .periph_resetn(periph_resetn),
    .core_resetn  (core_resetn),
    .busy         (busy),
    .reset_count  (reset_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        p;
    logic        c;
    logic        b;
    logic [15:0] n;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: two-stage delay lines for the async inputs, debounce
  // from time since last agreement, release from lock-high time and timestamps.
  int   k = 0;
  logic mb1, mb2, ml1, ml2, mlp, mdb, mpress;
  int   t_agree, hi, t_per, cnt;

  always @(posedge clk) begin : model
    exp_t e;
    logic trig, flip, np;
    k++;
    if (!resetn) begin
      mb1 = ~BA; mb2 = ~BA; mdb = ~BA;
      ml1 = 1'b0; ml2 = 1'b0; mlp = 1'b0;
      mpress = 1'b0; t_agree = k;
      hi = 0; t_per = 0; cnt = 0;
    end else begin
      trig = mpress | sw_reset_req | (mlp & ~ml2);
      if (mb2 == mdb) t_agree = k;
      flip = (mb2 != mdb) && (k - t_agree == D);
      np = flip && (mb2 == BA);
      if (flip) begin
        mdb = mb2;
        t_agree = k;
      end
      if (trig) begin
        if (cnt < 65535) cnt++;
        hi = 0;
      end else if (hi < H && ml2) begin
        hi++;
        if (hi == H) t_per = k;
      end
      mpress = np;
      mlp = ml2; ml2 = ml1; ml1 = locked;
      mb2 = mb1; mb1 = button_in;
    end
    e.p = (hi >= H);
    e.c = e.p && (k - t_per >= S);
    e.b = !e.c;
    e.n = 16'(cnt);
    sb_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      if (e != {periph_resetn, core_resetn, busy, reset_count}) begin
        n_fail++;
        $display("FAIL cycle_outputs at %0t: got p=%0b c=%0b b=%0b n=%0d expected p=%0b c=%0b b=%0b n=%0d",
                 $time, periph_resetn, core_resetn, busy, reset_count,
                 e.p, e.c, e.b, e.n);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Negedges until the selected output reaches val; -1 if budget expires.
  task automatic wait_sig(input bit use_core, input logic val,
                          input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((use_core ? core_resetn : periph_resetn) == val) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int lat;
  int c0;

  initial begin
    resetn = 1'b0;
    idle(3);
    chk("reset_periph", periph_resetn, 0);
    chk("reset_busy", busy, 1);
    idle(2);
    resetn = 1'b1;
    wait_sig(0, 1'b1, 50, lat);
    chk("powerup_periph_lat", lat, H + 2);
    wait_sig(1, 1'b1, 50, lat);
    chk("powerup_core_lat", lat, S);
    chk("powerup_busy", busy, 0);
    chk("powerup_count", reset_count, 0);
    idle(5);

    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    chk("sw_low_next", {periph_resetn, core_resetn}, 0);
    wait_sig(0, 1'b1, 50, lat);
    chk("sw_hold_len", lat, H);
    wait_sig(1, 1'b1, 50, lat);
    chk("sw_stagger_len", lat, S);
    chk("sw_count", reset_count, 1);
    idle(5);

    button_in = BA;
    idle(5);
    button_in = ~BA;
    idle(30);
    chk("glitch_count", reset_count, 1);

    button_in = BA;
    wait_sig(0, 1'b0, 60, lat);
    chk("press_lat", lat, 2 + D + 1);
    idle(40 - lat);
    button_in = ~BA;
    idle(60);
    chk("press_count", reset_count, 2);

    locked = 1'b0;
    wait_sig(0, 1'b0, 20, lat);
    chk("lockloss_lat", lat, 3);
    idle(17);
    locked = 1'b1;
    wait_sig(0, 1'b1, 50, lat);
    chk("lock_return_lat", lat, 2 + H);
    wait_sig(1, 1'b1, 50, lat);
    chk("lock_core_lat", lat, S);
    chk("lock_count", reset_count, 3);
    idle(5);

    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    wait_sig(0, 1'b1, 50, lat);
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    chk("retrig_stagger", {periph_resetn, core_resetn}, 0);
    wait_sig(0, 1'b1, 50, lat);
    chk("retrig_full_hold", lat, H);
    idle(20);

    c0 = reset_count;
    button_in = BA;
    idle(10);
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    idle(30);
    button_in = ~BA;
    idle(30);
    chk("simultaneous_count", reset_count, c0 + 1);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      sw_reset_req = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 79) == 0) button_in = ~button_in;
      if ($urandom_range(0, 149) == 0) locked = ~locked;
    end
    sw_reset_req = 1'b0;
    button_in = ~BA;
    locked = 1'b1;
    idle(40);

    sw_reset_req = 1'b1;
    idle(65540);
    sw_reset_req = 1'b0;
    chk("sat_count", reset_count, 16'hFFFF);
    wait_sig(0, 1'b1, 50, lat);
    chk("sat_hold_len", lat, H);
    wait_sig(1, 1'b1, 50, lat);
    chk("sat_stagger_len", lat, S);
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    chk("sat_still_low", periph_resetn, 0);
    chk("sat_hold", reset_count, 16'hFFFF);
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
